// File: rtl/inbuf_row_scheduler_pkg.sv
// inbuf_sched_pkg: FSM encoding and frame constants shared by the row scheduler files
package inbuf_sched_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_CMD, S_DRAIN, S_DONE} state_e;
  localparam logic [7:0] MIN_PIC_SIZE  = 8'd3;
  localparam logic [7:0] PREROLL_NOPAD = 8'd3;
  localparam logic [7:0] PREROLL_PAD   = 8'd2;
endpackage

// File: rtl/inbuf_row_scheduler_if.sv
// inbuf_row_scheduler_if: upstream row stream plus input-buffer write, command and observe ports
interface inbuf_row_scheduler_if #(parameter int IB_SRAM_AW = 10, parameter int MAX_CHANNEL_NUM = 128);
  logic [MAX_CHANNEL_NUM-1:0] src_data_i, ib_din_o;
  logic                       src_vld_i, src_rdy_o;
  logic                       ib_din_vld_o, ib_din_rdy_i, ib_sop_o, ib_hsync_o;
  logic [IB_SRAM_AW-1:0]      ib_start_waddr_o;
  logic                       ib_cmd_vld_o, ib_cmd_rdy_i, ib_padding_o;
  logic [7:0]                 ib_pic_size_o;
  logic [3:0]                 ib_mode_o;
  logic                       ib_dout_vld_i, ib_dout_rdy_i;
  modport master (
    input  src_data_i, src_vld_i, ib_din_rdy_i, ib_cmd_rdy_i, ib_dout_vld_i, ib_dout_rdy_i,
    output src_rdy_o, ib_din_o, ib_din_vld_o, ib_sop_o, ib_hsync_o, ib_start_waddr_o,
           ib_cmd_vld_o, ib_pic_size_o, ib_mode_o, ib_padding_o
  );
  modport slave (
    output src_data_i, src_vld_i, ib_din_rdy_i, ib_cmd_rdy_i, ib_dout_vld_i, ib_dout_rdy_i,
    input  src_rdy_o, ib_din_o, ib_din_vld_o, ib_sop_o, ib_hsync_o, ib_start_waddr_o,
           ib_cmd_vld_o, ib_pic_size_o, ib_mode_o, ib_padding_o
  );
endinterface

// File: rtl/inbuf_row_scheduler_addr_gen.sv
// inbuf_row_addr_gen: row start address base + row*P, wrapping at the SRAM address width
module inbuf_row_addr_gen #(parameter int IB_SRAM_AW = 10) (
  input  logic [IB_SRAM_AW-1:0] base_i,
  input  logic [7:0]            p_i,
  input  logic [7:0]            row_i,
  output logic [IB_SRAM_AW-1:0] waddr_o
);
  assign waddr_o = base_i + IB_SRAM_AW'(row_i) * IB_SRAM_AW'(p_i);
endmodule

// File: rtl/inbuf_row_scheduler.sv
// inbuf_row_scheduler: writes P rows into the input buffer, interleaving compute commands and drains.
// Define INBUF_SCHED_PERF_CNT_EN to add saturating stall/frame performance counters.
module inbuf_row_scheduler
  import inbuf_sched_pkg::*;
#(
  parameter int IB_SRAM_AW      = 10,
  parameter int MAX_CHANNEL_NUM = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_start_i,
  input  logic [7:0]            cfg_pic_size_i,
  input  logic [3:0]            cfg_mode_i,
  input  logic                  cfg_padding_i,
  input  logic [IB_SRAM_AW-1:0] cfg_base_addr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
`ifdef INBUF_SCHED_PERF_CNT_EN
  output logic [31:0]           perf_stall_cnt_o,
  output logic [15:0]           perf_frame_cnt_o,
`endif
  inbuf_row_scheduler_if.master bus
);
  state_e                state_q;
  logic [7:0]            p_q, row_q, beat_q, drain_q, cmd_q;
  logic [3:0]            mode_q;
  logic                  pad_q, err_q;
  logic [IB_SRAM_AW-1:0] base_q, waddr;
  logic                  in_wr, w_xfer, c_xfer, d_xfer, last_beat;
  logic [7:0]            pre, n_out;
  assign in_wr     = state_q == S_WRITE;
  assign w_xfer    = in_wr & bus.src_vld_i & bus.ib_din_rdy_i;
  assign c_xfer    = (state_q == S_CMD) & bus.ib_cmd_rdy_i;
  assign d_xfer    = (state_q == S_DRAIN) & bus.ib_dout_vld_i & bus.ib_dout_rdy_i;
  assign last_beat = beat_q == p_q - 8'd1;
  assign pre       = pad_q ? PREROLL_PAD : PREROLL_NOPAD;
  // output rows per frame doubles as the drain length per command
  assign n_out     = pad_q ? p_q : p_q - 8'd2;
  inbuf_row_addr_gen #(.IB_SRAM_AW(IB_SRAM_AW)) u_addr (
    .base_i(base_q), .p_i(p_q), .row_i(row_q), .waddr_o(waddr)
  );
  assign bus.src_rdy_o        = in_wr & bus.ib_din_rdy_i;
  assign bus.ib_din_vld_o     = in_wr & bus.src_vld_i;
  assign bus.ib_din_o         = in_wr ? bus.src_data_i : '0;
  assign bus.ib_sop_o         = in_wr & (row_q == 8'd0) & (beat_q == 8'd0);
  assign bus.ib_hsync_o       = in_wr & last_beat;
  assign bus.ib_start_waddr_o = waddr;
  assign bus.ib_cmd_vld_o     = state_q == S_CMD;
  assign bus.ib_pic_size_o    = p_q;
  assign bus.ib_mode_o        = mode_q;
  assign bus.ib_padding_o     = pad_q;
  assign busy_o               = state_q != S_IDLE;
  assign done_o               = state_q == S_DONE;
  assign err_o                = err_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      p_q     <= '0;
      row_q   <= '0;
      beat_q  <= '0;
      drain_q <= '0;
      cmd_q   <= '0;
      mode_q  <= '0;
      pad_q   <= 1'b0;
      base_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cfg_start_i) begin
          if (cfg_pic_size_i < MIN_PIC_SIZE) err_q <= 1'b1;
          else begin
            p_q     <= cfg_pic_size_i;
            mode_q  <= cfg_mode_i;
            pad_q   <= cfg_padding_i;
            base_q  <= cfg_base_addr_i;
            row_q   <= '0;
            beat_q  <= '0;
            drain_q <= '0;
            cmd_q   <= '0;
            state_q <= S_WRITE;
          end
        end
        S_WRITE: if (w_xfer) begin
          beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
          if (last_beat) begin
            row_q <= row_q + 8'd1;
            if (row_q + 8'd1 >= pre) state_q <= S_CMD;
          end
        end
        S_CMD: if (c_xfer) begin
          cmd_q   <= cmd_q + 8'd1;
          state_q <= S_DRAIN;
        end
        S_DRAIN: if (d_xfer) begin
          drain_q <= drain_q == n_out - 8'd1 ? 8'd0 : drain_q + 8'd1;
          if (drain_q == n_out - 8'd1)
            state_q <= cmd_q == n_out ? S_DONE : row_q < p_q ? S_WRITE : S_CMD;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
`ifdef INBUF_SCHED_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [15:0] frame_q;
  logic        stall;
  assign stall = busy_o & ~(w_xfer | c_xfer | d_xfer);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      frame_q <= '0;
    end else begin
      if (stall && !(&stall_q)) stall_q <= stall_q + 32'd1;
      if (done_o && !(&frame_q)) frame_q <= frame_q + 16'd1;
    end
  end
  assign perf_stall_cnt_o = stall_q;
  assign perf_frame_cnt_o = frame_q;
`endif
endmodule

// File: doc/inbuf_row_scheduler.md
INBUF_ROW_SCHEDULER -- requirements
Module: inbuf_row_scheduler

Interface
REQ-001 SHALL have parameter IB_SRAM_AW, default 10, input-buffer SRAM word-address width.
REQ-002 SHALL have parameter MAX_CHANNEL_NUM, default 128, data beat width in bits.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports cfg_start_i in 1 (start pulse), cfg_pic_size_i in 8, cfg_mode_i in 4, cfg_padding_i in 1, cfg_base_addr_i in IB_SRAM_AW; these are the frame descriptor.
REQ-006 SHALL have ports busy_o out 1, done_o out 1 (one-cycle pulse), err_o out 1 (one-cycle pulse).
REQ-007 SHALL have ports src_data_i in MAX_CHANNEL_NUM, src_vld_i in 1, src_rdy_o out 1; this is the upstream row-data stream.
REQ-008 SHALL have buffer write ports ib_din_o out MAX_CHANNEL_NUM, ib_din_vld_o out 1, ib_din_rdy_i in 1, ib_sop_o out 1, ib_hsync_o out 1, ib_start_waddr_o out IB_SRAM_AW.
REQ-009 SHALL have buffer command ports ib_cmd_vld_o out 1, ib_cmd_rdy_i in 1, ib_pic_size_o out 8, ib_mode_o out 4, ib_padding_o out 1.
REQ-010 SHALL have ports ib_dout_vld_i in 1 and ib_dout_rdy_i in 1; the block only observes this output handshake.

Function
REQ-011 SHALL latch the descriptor on cfg_start_i in IDLE; cfg_start_i outside IDLE is ignored.
REQ-012 SHALL reject pic_size < 3: stay IDLE, pulse err_o the next cycle, no buffer activity.
REQ-013 SHALL use FSM states IDLE, WRITE, CMD, DRAIN, DONE; DONE lasts one cycle, pulses done_o, then returns to IDLE.
REQ-014 Frame: P = pic_size. Rows R = P; beats per row = P; output rows OR = P with padding, P-2 without.
REQ-015 WRITE SHALL pass src to ib_din combinationally (ib_din_vld_o = src_vld_i, src_rdy_o = ib_din_rdy_i); a beat transfers when vld and rdy are both high.
REQ-016 ib_sop_o SHALL be high on beat 0 of row 0 only; ib_hsync_o SHALL be high on the last beat of every row.
REQ-017 ib_start_waddr_o SHALL equal (base + row_idx*P) mod 2^IB_SRAM_AW, held stable for the whole row.
REQ-018 First entry to CMD SHALL occur after 3 rows are written (2 with padding); each later CMD after one more row, until all R rows are written.
REQ-019 CMD SHALL hold ib_cmd_vld_o high with the latched pic_size/mode/padding until ib_cmd_rdy_i; on handshake go to DRAIN.
REQ-020 DRAIN SHALL count ib_dout_vld_i & ib_dout_rdy_i beats: P with padding, P-2 without. At count end: if issued commands = OR go to DONE; else if rows written < R go to WRITE; else go to CMD.
REQ-021 busy_o SHALL be high in every state except IDLE; src_rdy_o, ib_din_vld_o and ib_cmd_vld_o SHALL be 0 outside their own state.
REQ-022 Counters SHALL be 8-bit row/beat counters; the address multiply/add SHALL wrap silently.

Reset
REQ-023 rst_i high SHALL asynchronously force IDLE and clear all counters; all outputs become 0, including busy_o, done_o, err_o, the vld outputs and ib_start_waddr_o.
REQ-024 Reset mid-frame SHALL abandon the frame; no done_o is produced.

Configuration
REQ-025 With INBUF_SCHED_PERF_CNT_EN defined, SHALL add outputs perf_stall_cnt_o (32 bits) and perf_frame_cnt_o (16 bits). stall_cnt counts cycles with busy_o=1 and no transfer on any active handshake; frame_cnt counts done_o pulses. Both saturate and both are cleared by reset.
REQ-026 Without INBUF_SCHED_PERF_CNT_EN, these ports and counters SHALL be absent, with no other behavioural change.

Structure
REQ-027 A shared package inbuf_sched_pkg SHALL hold the FSM state encoding, the minimum pic size (3) and the pre-roll row counts (3 and 2).
REQ-028 The address generator SHALL be a sub-module inbuf_row_addr_gen (base, P, row_idx -> waddr); everything else stays in one module.

Verification
REQ-029 P=4, no padding, base=0, src always valid, rdy=1 -> 3 rows written at waddr 0, 4, 8; cmd; 2 dout beats; row 3 at waddr 12; cmd; 2 beats; done_o once.
REQ-030 P=4, padding -> 2 rows, then cmd and 4 beats repeated; 4 commands total; done_o.
REQ-031 P=2 start -> err_o one pulse, busy_o stays 0, no ib_din_vld_o.
REQ-032 base=1020, AW=10, P=5 -> row waddrs 1020, 1, 6 (wrap).
REQ-033 ib_din_rdy_i toggled every other cycle and ib_cmd_rdy_i delayed 7 cycles -> no lost or duplicated beats, sop/hsync on the correct beats, cmd_vld held 8 cycles.
REQ-034 rst_i asserted mid-DRAIN -> outputs 0 in the same cycle; a new start after release runs a clean frame.
